// File: rtl/nivel_pkg.sv
// nivel_pkg: shared FSM states, valid level codes and code check for nivel_sensor_cond
package nivel_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        OK      = 2'd1,
        SUSPECT = 2'd2,
        FAULT   = 2'd3
    } nivel_state_t;

    // Physically consistent thermometer codes {Nv2,Nv1,Nv0}
    localparam logic [2:0] NV_EMPTY = 3'b000;
    localparam logic [2:0] NV_LOW   = 3'b001;
    localparam logic [2:0] NV_MID   = 3'b011;
    localparam logic [2:0] NV_FULL  = 3'b111;

    function automatic logic is_valid_code(input logic [2:0] code);
        return (code == NV_EMPTY) || (code == NV_LOW) || (code == NV_MID) || (code == NV_FULL);
    endfunction

endpackage

// File: rtl/nivel_debounce.sv
// nivel_debounce: one float-switch probe, optional 2-flop synchroniser (NIVEL_SYNC_EN) then debounce counter
module nivel_debounce
    import nivel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sample;
    logic [CW-1:0] cnt;

`ifdef NIVEL_SYNC_EN
    logic [1:0] sync;

    // two-flop synchroniser for the asynchronous probe input
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync <= '0;
        else
            sync <= {sync[0], raw};
    end

    assign sample = sync[1];
`else
    assign sample = raw;
`endif

    // flip the debounced value once DEBOUNCE_CYCLES consecutive samples disagree with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (sample == db) begin
            cnt <= '0;
        end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sample;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nivel_sensor_cond.sv
// nivel_sensor_cond: debounces the three reservoir probes and publishes only consistent level codes
// Optional synchroniser stage enabled by defining NIVEL_SYNC_EN.
module nivel_sensor_cond
    import nivel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FAULT_CYCLES    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic s0_raw,
    input  logic s1_raw,
    input  logic s2_raw,
    output logic Nv0,
    output logic Nv1,
    output logic Nv2,
    output logic lvl_valid,
    output logic lvl_err,
    output logic lvl_chg
);

    // INIT waits out the full input pipeline so the first code seen is settled
`ifdef NIVEL_SYNC_EN
    localparam int INIT_CYCLES = DEBOUNCE_CYCLES + 2;
`else
    localparam int INIT_CYCLES = DEBOUNCE_CYCLES;
`endif
    localparam int TW = $clog2(INIT_CYCLES + 1);
    localparam int FW = $clog2(FAULT_CYCLES + 1);

    nivel_state_t  state;
    logic [TW-1:0] tmr;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] rcnt;
    logic [2:0]    nv;
    logic [2:0]    code;
    logic          code_ok;

    nivel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk   (clk),
        .reset (reset),
        .raw   (s0_raw),
        .db    (code[0])
    );

    nivel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk   (clk),
        .reset (reset),
        .raw   (s1_raw),
        .db    (code[1])
    );

    nivel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk   (clk),
        .reset (reset),
        .raw   (s2_raw),
        .db    (code[2])
    );

    assign code_ok = is_valid_code(code);
    assign Nv0     = nv[0];
    assign Nv1     = nv[1];
    assign Nv2     = nv[2];

    // supervisory FSM: publish valid codes, hold through short inconsistencies, latch persistent faults
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            tmr       <= '0;
            fcnt      <= '0;
            rcnt      <= '0;
            nv        <= NV_EMPTY;
            lvl_valid <= 1'b0;
            lvl_err   <= 1'b0;
            lvl_chg   <= 1'b0;
        end else begin
            lvl_chg <= 1'b0;
            case (state)
                INIT: begin
                    if (tmr >= TW'(INIT_CYCLES - 1)) begin
                        tmr <= '0;
                        if (code_ok) begin
                            state     <= OK;
                            nv        <= code;
                            lvl_valid <= 1'b1;
                            lvl_chg   <= 1'b1;
                        end else begin
                            state <= SUSPECT;
                            fcnt  <= FW'(1);
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                OK: begin
                    if (!code_ok) begin
                        state     <= SUSPECT;
                        fcnt      <= FW'(1);
                        lvl_valid <= 1'b0;
                    end else if (code != nv) begin
                        nv      <= code;
                        lvl_chg <= 1'b1;
                    end
                end
                SUSPECT: begin
                    if (code_ok) begin
                        state     <= OK;
                        fcnt      <= '0;
                        lvl_valid <= 1'b1;
                        nv        <= code;
                        lvl_chg   <= (code != nv);
                    end else if (fcnt >= FW'(FAULT_CYCLES - 1)) begin
                        state   <= FAULT;
                        fcnt    <= '0;
                        rcnt    <= '0;
                        lvl_err <= 1'b1;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                FAULT: begin
                    if (!code_ok) begin
                        rcnt <= '0;
                    end else if (rcnt >= FW'(FAULT_CYCLES - 1)) begin
                        state     <= OK;
                        rcnt      <= '0;
                        lvl_err   <= 1'b0;
                        lvl_valid <= 1'b1;
                        nv        <= code;
                        lvl_chg   <= 1'b1;
                    end else begin
                        rcnt <= rcnt + FW'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_nivel_sensor_cond.sv
// tb_nivel_sensor_cond: directed scoreboard bench for nivel_sensor_cond (DEBOUNCE_CYCLES=4, FAULT_CYCLES=16)
module tb_nivel_sensor_cond;

    localparam int D = 4;
    localparam int F = 16;
`ifdef NIVEL_SYNC_EN
    localparam int LAT = D + 2;
`else
    localparam int LAT = D;
`endif

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    logic clk;
    logic reset;
    logic s0_raw, s1_raw, s2_raw;
    logic Nv0, Nv1, Nv2, lvl_valid, lvl_err, lvl_chg;
    logic [5:0] obs;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    nivel_sensor_cond #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
        .clk       (clk),
        .reset     (reset),
        .s0_raw    (s0_raw),
        .s1_raw    (s1_raw),
        .s2_raw    (s2_raw),
        .Nv0       (Nv0),
        .Nv1       (Nv1),
        .Nv2       (Nv2),
        .lvl_valid (lvl_valid),
        .lvl_err   (lvl_err),
        .lvl_chg   (lvl_chg)
    );

    // {Nv2,Nv1,Nv0,lvl_valid,lvl_err,lvl_chg}
    assign obs = {Nv2, Nv1, Nv0, lvl_valid, lvl_err, lvl_chg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pop_check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: got %b required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) passes++;
            else begin
                fails++;
                $error("FAIL %s: got %b required %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [5:0] e);
        sb.push_back('{tag, e});
        pop_check();
    endtask

    task automatic hold(input string tag, input logic [5:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{tag, e});
            @(posedge clk);
            #1;
            pop_check();
        end
    endtask

    initial begin
        reset  = 1'b1;
        s0_raw = 1'b0;
        s1_raw = 1'b0;
        s2_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 6'b000_000);
        reset = 1'b0;

        // INIT timer then first publish of 000
        hold("init_wait", 6'b000_000, LAT - 1);
        hold("init_pub", 6'b000_101, 1);
        hold("init_idle", 6'b000_100, 2);

        // 000 -> 001
        s0_raw = 1'b1;
        hold("low_wait", 6'b000_100, LAT);
        hold("low_pub", 6'b001_101, 1);
        hold("low_idle", 6'b001_100, 2);

        // short glitch on middle probe is swallowed
        s1_raw = 1'b1;
        hold("glitch_on", 6'b001_100, 3);
        s1_raw = 1'b0;
        hold("glitch_off", 6'b001_100, LAT + 4);

        // inconsistent 101 -> SUSPECT then FAULT, published code held at 001
        s2_raw = 1'b1;
        hold("bad_wait", 6'b001_100, LAT);
        hold("suspect", 6'b001_000, F - 1);
        hold("fault", 6'b001_010, 4);

        // recovery with 011, interrupted at recovery count 10
        s2_raw = 1'b0;
        s1_raw = 1'b1;
        hold("rec_a", 6'b001_010, 10);
        s0_raw = 1'b0;
        hold("rec_break", 6'b001_010, D);
        s0_raw = 1'b1;
        hold("rec_b", 6'b001_010, LAT + F - 1);
        hold("rec_exit", 6'b011_101, 1);
        hold("rec_idle", 6'b011_100, 2);

        // invalid 010 into SUSPECT, then reset mid-SUSPECT
        s0_raw = 1'b0;
        hold("sus2_wait", 6'b011_100, LAT);
        hold("sus2", 6'b011_000, 3);
        reset  = 1'b1;
        s1_raw = 1'b0;
        #1;
        check_now("async_reset", 6'b000_000);
        hold("reset_hold", 6'b000_000, 2);
        reset = 1'b0;
        hold("reinit_wait", 6'b000_000, LAT - 1);
        hold("reinit_pub", 6'b000_101, 1);
        hold("reinit_idle", 6'b000_100, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
